// File: rtl/nibble_demux.sv
// Assembles two tagged nibbles into a byte behind valid/ready handshakes on both sides.
// Optional partial-byte timeout is enabled by defining NIBBLE_DEMUX_TIMEOUT_EN.
module nibble_demux #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] nib_data,
  input  logic       nib_sel,
  input  logic       nib_valid,
  output logic       nib_ready,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       overwrite,
  output logic       timeout
);

  typedef enum logic [1:0] {EMPTY, LO, HI, FULL} state_t;

  state_t state;
  state_t next_state;
  logic   accept;
  logic   partial;
  logic   expire;

  assign nib_ready = (state != FULL);
  assign accept    = nib_valid && nib_ready;
  assign partial   = (state == LO) || (state == HI);

`ifdef NIBBLE_DEMUX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] idle_cnt;

  // An accept in the expiry cycle takes priority over discarding the partial byte.
  assign expire = partial && !accept && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Idle counter only advances while a half byte is waiting for its partner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (accept || expire || !partial) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign expire                = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      EMPTY: begin
        if (accept) next_state = nib_sel ? HI : LO;
      end
      LO: begin
        if (accept && nib_sel) next_state = FULL;
        else if (expire)       next_state = EMPTY;
      end
      HI: begin
        if (accept && !nib_sel) next_state = FULL;
        else if (expire)        next_state = EMPTY;
      end
      FULL: begin
        if (byte_ready) next_state = EMPTY;
      end
      default: next_state = EMPTY;
    endcase
  end

  // State, byte register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      overwrite  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= next_state;
      byte_valid <= (next_state == FULL);
      overwrite  <= accept && (((state == LO) && !nib_sel) || ((state == HI) && nib_sel));
      timeout    <= expire;
      if (accept) begin
        if (nib_sel) byte_data[7:4] <= nib_data;
        else         byte_data[3:0] <= nib_data;
      end
    end
  end

endmodule

// File: tb/tb_nibble_demux.sv
// Directed bench for nibble_demux; follows NIBBLE_DEMUX_TIMEOUT_EN to pick timeout expectations.
module tb_nibble_demux;

  logic       clk;
  logic       rst_n;
  logic [3:0] nib_data;
  logic       nib_sel;
  logic       nib_valid;
  logic       nib_ready;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       overwrite;
  logic       timeout;

  int total;
  int bad;

  nibble_demux #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nib_data   (nib_data),
    .nib_sel    (nib_sel),
    .nib_valid  (nib_valid),
    .nib_ready  (nib_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .overwrite  (overwrite),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [3:0] data);
    nib_valid = 1'b1;
    nib_sel   = sel;
    nib_data  = data;
    tick();
    nib_valid = 1'b0;
  endtask

  task automatic consume();
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    nib_data   = 4'h0;
    nib_sel    = 1'b0;
    nib_valid  = 1'b0;
    byte_ready = 1'b0;
    #1;
    chk("rst_byte_valid", 8'(byte_valid), 8'h00);
    chk("rst_byte_data",  byte_data,      8'h00);
    chk("rst_nib_ready",  8'(nib_ready),  8'h01);
    chk("rst_overwrite",  8'(overwrite),  8'h00);
    chk("rst_timeout",    8'(timeout),    8'h00);
    tick();
    rst_n = 1'b1;

    // Reset in the middle of a partial byte
    push(1'b0, 4'h9);
    chk("lo_byte_data", byte_data, 8'h09);
    chk("lo_valid",     8'(byte_valid), 8'h00);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_byte_valid", 8'(byte_valid), 8'h00);
    chk("midrst_byte_data",  byte_data,      8'h00);
    chk("midrst_nib_ready",  8'(nib_ready),  8'h01);
    rst_n = 1'b1;

    // Low then high
    push(1'b0, 4'h5);
    chk("t2_valid_after_lo", 8'(byte_valid), 8'h00);
    push(1'b1, 4'hA);
    chk("t2_byte_valid", 8'(byte_valid), 8'h01);
    chk("t2_byte_data",  byte_data,      8'hA5);
    chk("t2_nib_ready",  8'(nib_ready),  8'h00);
    consume();
    chk("t2_pop_valid", 8'(byte_valid), 8'h00);
    chk("t2_pop_ready", 8'(nib_ready),  8'h01);
    chk("t2_pop_hold",  byte_data,      8'hA5);

    // High then low
    push(1'b1, 4'h3);
    chk("t3_ow_a", 8'(overwrite), 8'h00);
    chk("t3_data_a", byte_data, 8'h35);
    push(1'b0, 4'hC);
    chk("t3_ow_b",       8'(overwrite),  8'h00);
    chk("t3_byte_data",  byte_data,      8'h3C);
    chk("t3_byte_valid", 8'(byte_valid), 8'h01);
    consume();
    chk("t3_ow_c", 8'(overwrite), 8'h00);

    // Low rewritten before completion
    push(1'b0, 4'h1);
    chk("t4_ow_a",   8'(overwrite), 8'h00);
    chk("t4_data_a", byte_data,     8'h31);
    push(1'b0, 4'h2);
    chk("t4_ow_b",    8'(overwrite),  8'h01);
    chk("t4_data_b",  byte_data,      8'h32);
    chk("t4_valid_b", 8'(byte_valid), 8'h00);
    push(1'b1, 4'hF);
    chk("t4_ow_c",    8'(overwrite),  8'h00);
    chk("t4_data_c",  byte_data,      8'hF2);
    chk("t4_valid_c", 8'(byte_valid), 8'h01);

    // Downstream stall with upstream pushing
    nib_valid = 1'b1;
    nib_sel   = 1'b0;
    nib_data  = 4'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_nib_ready",  8'(nib_ready),  8'h00);
      chk("t5_byte_data",  byte_data,      8'hF2);
      chk("t5_byte_valid", 8'(byte_valid), 8'h01);
      chk("t5_overwrite",  8'(overwrite),  8'h00);
    end
    nib_valid = 1'b0;
    consume();
    chk("t5_pop_valid", 8'(byte_valid), 8'h00);

    // Idle with a half byte held
    push(1'b0, 4'h7);
    chk("t6_data", byte_data, 8'hF7);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t6_idle_timeout", 8'(timeout),   8'h00);
      chk("t6_idle_ready",   8'(nib_ready), 8'h01);
    end
    tick();
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
    chk("t6_timeout_pulse", 8'(timeout),  8'h01);
    chk("t6_timeout_data",  byte_data,    8'hF7);
    tick();
    chk("t6_timeout_end", 8'(timeout), 8'h00);
    push(1'b1, 4'h4);
    chk("t6_empty_after", 8'(byte_valid), 8'h00);
    chk("t6_empty_data",  byte_data,      8'h47);
    push(1'b0, 4'h6);
    chk("t6_refill_valid", 8'(byte_valid), 8'h01);
    chk("t6_refill_data",  byte_data,      8'h46);
    consume();

    // Accept coinciding with expiry wins
    push(1'b0, 4'h1);
    for (int i = 1; i < 8; i++) tick();
    push(1'b1, 4'h8);
    chk("t6_race_timeout", 8'(timeout),    8'h00);
    chk("t6_race_valid",   8'(byte_valid), 8'h01);
    chk("t6_race_data",    byte_data,      8'h81);
    consume();
`else
    chk("t6_no_timeout", 8'(timeout), 8'h00);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_no_timeout_late", 8'(timeout), 8'h00);
    push(1'b1, 4'h4);
    chk("t6_still_lo_valid", 8'(byte_valid), 8'h01);
    chk("t6_still_lo_data",  byte_data,      8'h47);
    consume();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
